// File: rtl/pwm_ctrl.sv
// rtl/pwm_ctrl.sv - PWM timer controller with shadowed reload/duty registers
// Optional feature macro: PWM_CTRL_RAMP_EN (duty ramps one LSB per period boundary)
module pwm_ctrl #(
  parameter int BITS     = 4,
  parameter int CHANNELS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [1:0]               i_wr_addr,
  input  logic [BITS-1:0]          i_wr_data,
  output logic                     o_wr_ack,
  input  logic [BITS-1:0]          i_counter,
  output logic                     o_tim_rst,
  output logic                     o_tim_dir,
  output logic                     o_tim_mode,
  output logic [BITS-1:0]          o_tim_reload,
  output logic [CHANNELS*BITS-1:0] o_pwm_set,
  output logic                     o_period_evt,
  output logic                     o_busy
);

  typedef enum logic [1:0] {S_OFF, S_ARM, S_RUN} state_t;

  localparam logic [BITS-1:0] L_CHANNELS = BITS'(CHANNELS);

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_ctrl;
  logic [BITS-1:0] r_sh_reload;
  logic [BITS-1:0] r_sh_duty [CHANNELS];
  logic [BITS-1:0] r_chan_sel;
  logic [BITS-1:0] r_act_reload;
  logic [BITS-1:0] r_act_duty [CHANNELS];
  logic            r_act_dir;
  logic            r_act_mode;
  logic            r_busy;
  logic            r_wr_ack;

  logic w_wr_ctrl;
  logic w_wr_reload;
  logic w_wr_csel;
  logic w_wr_duty;
  logic w_duty_hit;
  logic w_enable;
  logic w_boundary;
  logic w_evt;
  logic w_upd_req;

  // Decode the register write and the period boundary for the active direction
  always_comb begin
    w_wr_ctrl   = i_wr_en && (i_wr_addr == 2'd0);
    w_wr_reload = i_wr_en && (i_wr_addr == 2'd1);
    w_wr_csel   = i_wr_en && (i_wr_addr == 2'd2);
    w_wr_duty   = i_wr_en && (i_wr_addr == 2'd3);
    w_duty_hit  = w_wr_duty && (r_chan_sel < L_CHANNELS);
    // A ctrl write takes effect on the state machine immediately so disable needs no extra cycle
    w_enable    = w_wr_ctrl ? i_wr_data[0] : r_ctrl[0];
    w_boundary  = r_act_dir ? (i_counter == r_act_reload) : (i_counter == '0);
    w_evt       = (r_state == S_RUN) && w_boundary;
    // Only writes that can change the running waveform flag a pending update
    w_upd_req   = (r_state != S_OFF) &&
                  (w_wr_reload || w_duty_hit || (w_wr_ctrl && i_wr_data[0]));
  end

`ifdef PWM_CTRL_RAMP_EN
  logic [BITS-1:0] w_step_duty [CHANNELS];
  logic            w_ramp_pending;

  // Move each active duty one LSB toward its shadow; note whether any is still short
  always_comb begin
    w_ramp_pending = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_step_duty[c] = r_act_duty[c];
      if (r_act_duty[c] < r_sh_duty[c]) begin
        w_step_duty[c] = r_act_duty[c] + BITS'(1);
      end else if (r_act_duty[c] > r_sh_duty[c]) begin
        w_step_duty[c] = r_act_duty[c] - BITS'(1);
      end
      if (w_step_duty[c] != r_sh_duty[c]) begin
        w_ramp_pending = 1'b1;
      end
    end
  end
`endif

  // Next-state logic: OFF -> ARM -> RUN, any state drops to OFF when enable clears
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF:   if (w_enable) w_next = S_ARM;
      S_ARM:   w_next = w_enable ? S_RUN : S_OFF;
      S_RUN:   if (!w_enable) w_next = S_OFF;
      default: w_next = S_OFF;
    endcase
  end

  // State, shadow/active registers, busy flag and write acknowledge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_OFF;
      r_ctrl       <= '0;
      r_sh_reload  <= '0;
      r_chan_sel   <= '0;
      r_act_reload <= '0;
      r_act_dir    <= 1'b0;
      r_act_mode   <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_ack     <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_sh_duty[c]  <= '0;
        r_act_duty[c] <= '0;
      end
    end else begin
      r_state  <= w_next;
      r_wr_ack <= i_wr_en;
      if (w_wr_ctrl)   r_ctrl      <= i_wr_data[2:0];
      if (w_wr_reload) r_sh_reload <= i_wr_data;
      if (w_wr_csel)   r_chan_sel  <= i_wr_data;
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr_duty && (r_chan_sel == BITS'(c))) r_sh_duty[c] <= i_wr_data;
      end
      // Active copies come from the pre-write shadows, so a coincident write waits a period
      if ((r_state == S_ARM) || w_evt) begin
        r_act_reload <= r_sh_reload;
        r_act_dir    <= r_ctrl[1];
        r_act_mode   <= r_ctrl[2];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_state == S_ARM) begin
          r_act_duty[c] <= r_sh_duty[c];
        end else if (w_evt) begin
`ifdef PWM_CTRL_RAMP_EN
          r_act_duty[c] <= w_step_duty[c];
`else
          r_act_duty[c] <= r_sh_duty[c];
`endif
        end
      end
      if (w_upd_req) begin
        r_busy <= 1'b1;
      end else if (r_state == S_ARM) begin
        r_busy <= 1'b0;
      end else if (w_evt) begin
`ifdef PWM_CTRL_RAMP_EN
        r_busy <= w_ramp_pending;
`else
        r_busy <= 1'b0;
`endif
      end
    end
  end

  // Drive timer controls; duty outputs are forced low unless running
  always_comb begin
    o_wr_ack     = r_wr_ack;
    o_tim_rst    = (r_state != S_RUN);
    o_tim_dir    = r_act_dir;
    o_tim_mode   = r_act_mode;
    o_tim_reload = r_act_reload;
    o_period_evt = w_evt;
    o_busy       = r_busy;
    o_pwm_set    = '0;
    if (r_state == S_RUN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        o_pwm_set[c*BITS +: BITS] = r_act_duty[c];
      end
    end
  end

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb/tb_pwm_ctrl.sv - directed self-checking bench for pwm_ctrl
module tb_pwm_ctrl;
  localparam int BITS     = 4;
  localparam int CHANNELS = 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr_en;
  logic [1:0]               wr_addr;
  logic [BITS-1:0]          wr_data;
  logic                     wr_ack;
  logic [BITS-1:0]          counter;
  logic                     tim_rst;
  logic                     tim_dir;
  logic                     tim_mode;
  logic [BITS-1:0]          tim_reload;
  logic [CHANNELS*BITS-1:0] pwm_set;
  logic                     period_evt;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  pwm_ctrl #(.BITS(BITS), .CHANNELS(CHANNELS)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ack(wr_ack), .i_counter(counter), .o_tim_rst(tim_rst), .o_tim_dir(tim_dir),
    .o_tim_mode(tim_mode), .o_tim_reload(tim_reload), .o_pwm_set(pwm_set),
    .o_period_evt(period_evt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Timer model: reload mode, counts up to reload or down from reload to 0
  always @(posedge clk) begin
    if (tim_rst) counter <= '0;
    else if (tim_dir) counter <= (counter == tim_reload) ? '0 : counter + 1'b1;
    else counter <= (counter == '0) ? tim_reload : counter - 1'b1;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [BITS-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_evt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (period_evt) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd5;
    tick; tick;
    checks++; if (tim_rst !== 1'b1) begin errors++; $display("FAIL rst_tim_rst got %0h exp 1", tim_rst); end
    checks++; if (tim_dir !== 1'b0 || tim_mode !== 1'b0) begin errors++; $display("FAIL rst_dir_mode got %0h%0h exp 00", tim_dir, tim_mode); end
    checks++; if (tim_reload !== 4'd0 || pwm_set !== 4'd0) begin errors++; $display("FAIL rst_values got %0h/%0h exp 0/0", tim_reload, pwm_set); end
    checks++; if (wr_ack !== 1'b0 || period_evt !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flags got %0h%0h%0h exp 000", wr_ack, period_evt, busy); end
    rst = 1'b0; wr_en = 1'b0;
    tick;
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL rst_write_lost got %0h exp 0", wr_ack); end
  endtask

  task automatic test_arm;
    do_write(2'd1, 4'd7);
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_pulse got %0h exp 1", wr_ack); end
    do_write(2'd2, 4'd0);
    do_write(2'd3, 4'd4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL off_write_busy got %0h exp 0", busy); end
    do_write(2'd0, 4'd7);
    checks++; if (tim_rst !== 1'b1 || pwm_set !== 4'd0) begin errors++; $display("FAIL arm_cycle got rst=%0h pwm=%0h exp 1/0", tim_rst, pwm_set); end
    tick;
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_single got %0h exp 0", wr_ack); end
    checks++; if (tim_rst !== 1'b0) begin errors++; $display("FAIL run_tim_rst got %0h exp 0", tim_rst); end
    checks++; if (pwm_set !== 4'd4 || tim_reload !== 4'd7) begin errors++; $display("FAIL run_values got pwm=%0h rl=%0h exp 4/7", pwm_set, tim_reload); end
    checks++; if (tim_dir !== 1'b1 || tim_mode !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL run_ctrl got %0h%0h%0h exp 110", tim_dir, tim_mode, busy); end
  endtask

  task automatic test_period;
    bit ok;
    int n;
    wait_evt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL period_timeout got 0 exp 1"); end
    checks++; if (counter !== 4'd7) begin errors++; $display("FAIL period_at_reload got %0h exp 7", counter); end
    tick;
    checks++; if (period_evt !== 1'b0) begin errors++; $display("FAIL period_one_cycle got %0h exp 0", period_evt); end
    n = 1;
    while (!period_evt && n < 40) begin tick; n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL period_length got %0d exp 8", n); end
    tick;
  endtask

  task automatic test_update;
    bit ok;
    tick; tick;
    do_write(2'd3, 4'd3);
    checks++; if (busy !== 1'b1 || pwm_set !== 4'd4) begin errors++; $display("FAIL upd_pending got busy=%0h pwm=%0h exp 1/4", busy, pwm_set); end
    wait_evt(ok);
    checks++; if (!ok || pwm_set !== 4'd4) begin errors++; $display("FAIL upd_at_boundary got ok=%0h pwm=%0h exp 1/4", ok, pwm_set); end
    tick;
    checks++; if (pwm_set !== 4'd3 || busy !== 1'b0) begin errors++; $display("FAIL upd_applied got pwm=%0h busy=%0h exp 3/0", pwm_set, busy); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    wait_evt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL coin_timeout got 0 exp 1"); end
    do_write(2'd3, 4'd4);
    checks++; if (pwm_set !== 4'd3 || busy !== 1'b1) begin errors++; $display("FAIL coin_deferred got pwm=%0h busy=%0h exp 3/1", pwm_set, busy); end
    wait_evt(ok);
    tick;
    checks++; if (!ok || pwm_set !== 4'd4 || busy !== 1'b0) begin errors++; $display("FAIL coin_next got pwm=%0h busy=%0h exp 4/0", pwm_set, busy); end
  endtask

  task automatic test_disable;
    bit ok;
    tick; tick; tick;
    do_write(2'd0, 4'd0);
    checks++; if (tim_rst !== 1'b1 || pwm_set !== 4'd0 || period_evt !== 1'b0) begin errors++; $display("FAIL disable_off got rst=%0h pwm=%0h evt=%0h exp 1/0/0", tim_rst, pwm_set, period_evt); end
    tick;
    do_write(2'd0, 4'd7);
    checks++; if (tim_rst !== 1'b1) begin errors++; $display("FAIL rearm_arm got %0h exp 1", tim_rst); end
    tick;
    checks++; if (tim_rst !== 1'b0 || pwm_set !== 4'd4 || tim_reload !== 4'd7) begin errors++; $display("FAIL rearm_restore got rst=%0h pwm=%0h rl=%0h exp 0/4/7", tim_rst, pwm_set, tim_reload); end
    do_write(2'd2, 4'd1);
    do_write(2'd3, 4'd9);
    checks++; if (wr_ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL chan_drop_ack got ack=%0h busy=%0h exp 1/0", wr_ack, busy); end
    wait_evt(ok);
    tick;
    checks++; if (!ok || pwm_set !== 4'd4) begin errors++; $display("FAIL chan_drop_kept got pwm=%0h exp 4", pwm_set); end
    do_write(2'd2, 4'd0);
  endtask

  task automatic test_duty_step;
    bit ok;
    do_write(2'd3, 4'd0);
    do_write(2'd0, 4'd0);
    do_write(2'd0, 4'd7);
    tick;
    checks++; if (pwm_set !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL step_start got pwm=%0h busy=%0h exp 0/0", pwm_set, busy); end
    do_write(2'd3, 4'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL step_busy got %0h exp 1", busy); end
`ifdef PWM_CTRL_RAMP_EN
    for (int k = 1; k <= 3; k++) begin
      wait_evt(ok);
      tick;
      checks++; if (!ok || pwm_set !== BITS'(k) || busy !== (k < 3)) begin errors++; $display("FAIL ramp_step%0d got pwm=%0h busy=%0h exp %0h/%0h", k, pwm_set, busy, k, (k < 3)); end
    end
`else
    wait_evt(ok);
    tick;
    checks++; if (!ok || pwm_set !== 4'd3 || busy !== 1'b0) begin errors++; $display("FAIL jump_step got pwm=%0h busy=%0h exp 3/0", pwm_set, busy); end
`endif
  endtask

  task automatic test_dir_down;
    bit ok;
    int n;
    do_write(2'd0, 4'd5);
    checks++; if (busy !== 1'b1 || tim_dir !== 1'b1) begin errors++; $display("FAIL dir_pending got busy=%0h dir=%0h exp 1/1", busy, tim_dir); end
    wait_evt(ok);
    checks++; if (!ok || counter !== 4'd7) begin errors++; $display("FAIL dir_old_boundary got cnt=%0h exp 7", counter); end
    tick;
    checks++; if (tim_dir !== 1'b0 || tim_mode !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dir_applied got %0h%0h%0h exp 010", tim_dir, tim_mode, busy); end
    wait_evt(ok);
    checks++; if (!ok || counter !== 4'd0) begin errors++; $display("FAIL dir_down_boundary got cnt=%0h exp 0", counter); end
    tick;
    n = 1;
    while (!period_evt && n < 40) begin tick; n++; end
    checks++; if (n != 8 || counter !== 4'd0) begin errors++; $display("FAIL dir_down_period got n=%0d cnt=%0h exp 8/0", n, counter); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset;
    test_arm;
    test_period;
    test_update;
    test_back_to_back;
    test_disable;
    test_duty_step;
    test_dir_down;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
